// File: rtl/sdram_arbiter.sv
// Two-requester arbiter (CPU byte port, video word fetch) in front of the SDRAM controller.
// Optional transaction watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter #(
    parameter logic [1:0] VID_BASE       = 2'b10,
    parameter int         CPU_STARVE_MAX = 2,
    parameter int         TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [13:0] vid_addr,
    output logic [15:0] vid_rdata,
    output logic        vid_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        VID_ACC = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  starve_cnt_r;
    logic        grant_cpu_s;
    logic        grant_vid_s;
    logic        in_acc_s;
    logic        finish_s;
    logic        tmo_s;

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic [7:0]  tmo_cnt_r;
    logic        err_r;

    assign tmo_s = in_acc_s && !mem_ack && (tmo_cnt_r == 8'(TIMEOUT - 1));
    assign err   = err_r;

    // Watchdog counter for the access states and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= 8'd0;
            err_r     <= 1'b0;
        end else begin
            if (grant_cpu_s || grant_vid_s) begin
                tmo_cnt_r <= 8'd0;
            end else if (in_acc_s) begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
            if (tmo_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end
`else
    logic [7:0]  unused_tmo_s;

    assign unused_tmo_s = 8'(TIMEOUT);
    assign tmo_s        = 1'b0;
    assign err          = 1'b0;
`endif

    assign in_acc_s = (state_r == CPU_ACC) || (state_r == VID_ACC);
    assign finish_s = in_acc_s && (mem_ack || tmo_s);

    // Arbitration: video by default, CPU once it has been passed over CPU_STARVE_MAX times.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_vid_s = 1'b0;
        if (state_r == IDLE) begin
            if (cpu_req && vid_req) begin
                if (starve_cnt_r >= 4'(CPU_STARVE_MAX)) begin
                    grant_cpu_s = 1'b1;
                end else begin
                    grant_vid_s = 1'b1;
                end
            end else if (cpu_req) begin
                grant_cpu_s = 1'b1;
            end else if (vid_req) begin
                grant_vid_s = 1'b1;
            end else begin
                grant_cpu_s = 1'b0;
            end
        end else begin
            grant_cpu_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_cpu_s) begin
                    state_s = CPU_ACC;
                end else if (grant_vid_s) begin
                    state_s = VID_ACC;
                end else begin
                    state_s = IDLE;
                end
            end
            CPU_ACC, VID_ACC: begin
                if (finish_s) begin
                    state_s = DONE;
                end else begin
                    state_s = state_r;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered controller request, return data, acks and starve counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 16'h0000;
            mem_wdata    <= 16'h0000;
            cpu_rdata    <= 8'h00;
            vid_rdata    <= 16'h0000;
            cpu_ack      <= 1'b0;
            vid_ack      <= 1'b0;
            starve_cnt_r <= 4'd0;
        end else begin
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            if (grant_cpu_s) begin
                mem_req      <= 1'b1;
                mem_we       <= cpu_we;
                mem_addr     <= cpu_addr;
                mem_wdata    <= {8'h00, cpu_wdata};
                starve_cnt_r <= 4'd0;
            end else if (grant_vid_s) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= {VID_BASE, vid_addr};
                mem_wdata <= 16'h0000;
                if (cpu_req && (starve_cnt_r != 4'd15)) begin
                    starve_cnt_r <= starve_cnt_r + 4'd1;
                end else begin
                    starve_cnt_r <= starve_cnt_r;
                end
            end else if (finish_s) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (state_r == CPU_ACC) begin
                    cpu_ack <= 1'b1;
                    if (tmo_s) begin
                        cpu_rdata <= 8'hFF;
                    end else if (!mem_we) begin
                        cpu_rdata <= mem_rdata[7:0];
                    end else begin
                        cpu_rdata <= cpu_rdata;
                    end
                end else begin
                    vid_ack   <= 1'b1;
                    vid_rdata <= tmo_s ? 16'hFFFF : mem_rdata;
                end
            end else begin
                mem_req <= mem_req;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected grants are queued when requests are
// driven and popped when the arbiter raises mem_req.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, vid_req, mem_ack;
    logic [15:0] cpu_addr, mem_rdata;
    logic [7:0]  cpu_wdata;
    logic [13:0] vid_addr;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack, vid_ack, mem_req, mem_we, err;
    logic [15:0] vid_rdata, mem_addr, mem_wdata;

    typedef struct packed {
        logic        is_cpu;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] rdat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    bit   ok;

    always #5 clk = ~clk;

    sdram_arbiter #(.VID_BASE(2'b10), .CPU_STARVE_MAX(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Controller model: ack in the dly-th cycle of the access with data d.
    task automatic mem_respond(input int dly, input logic [15:0] d);
        repeat (dly - 1) tick();
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_vec++;
        if ({cpu_rdata, cpu_ack, vid_rdata, vid_ack, mem_req, mem_we, mem_addr, mem_wdata, err} !== 61'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {cpu_rdata, cpu_ack, vid_rdata, vid_ack, mem_req, mem_we, mem_addr, mem_wdata, err});
        end
    endtask

    task automatic test_cpu_read();
        exp_q.push_back('{1'b1, 16'h1234, 1'b0, 16'h0077, 16'h00EF});
        cpu_addr = 16'h1234; cpu_we = 1'b0; cpu_wdata = 8'h77; cpu_req = 1'b1;
        wait_grant(ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL cpu_read_grant: no mem_req within 20 cycles"); end
        e = exp_q.pop_front();
        n_vec++;
        if ({mem_addr, mem_we, mem_wdata} !== {e.addr, e.we, e.wdata}) begin
            n_err++;
            $display("FAIL cpu_read_req: got %h/%b/%h expected %h/%b/%h", mem_addr, mem_we, mem_wdata, e.addr, e.we, e.wdata);
        end
        mem_respond(2, 16'hBEEF);
        n_vec++;
        if ({cpu_ack, vid_ack, mem_req, cpu_rdata} !== {3'b100, e.rdat[7:0]}) begin
            n_err++;
            $display("FAIL cpu_read_ack: got ack=%b vack=%b req=%b rd=%h expected 1 0 0 %h", cpu_ack, vid_ack, mem_req, cpu_rdata, e.rdat[7:0]);
        end
        cpu_req = 1'b0;
        tick();
        n_vec++;
        if ({cpu_ack, vid_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL cpu_read_pulse: got ack=%b vack=%b expected 0 0", cpu_ack, vid_ack);
        end
    endtask

    task automatic test_cpu_write();
        exp_q.push_back('{1'b1, 16'hF700, 1'b1, 16'h0001, 16'h00EF});
        cpu_addr = 16'hF700; cpu_we = 1'b1; cpu_wdata = 8'h01; cpu_req = 1'b1;
        wait_grant(ok);
        e = exp_q.pop_front();
        n_vec++;
        if (!ok || {mem_addr, mem_we, mem_wdata} !== {e.addr, e.we, e.wdata}) begin
            n_err++;
            $display("FAIL cpu_write_req: got %h/%b/%h expected %h/%b/%h", mem_addr, mem_we, mem_wdata, e.addr, e.we, e.wdata);
        end
        mem_respond(1, 16'h5555);
        n_vec++;
        if ({cpu_ack, mem_we, cpu_rdata} !== {2'b10, e.rdat[7:0]}) begin
            n_err++;
            $display("FAIL cpu_write_ack: got ack=%b we=%b rd=%h expected 1 0 %h", cpu_ack, mem_we, cpu_rdata, e.rdat[7:0]);
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
        n_vec++;
        if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL cpu_write_pulse: got %b expected 0", cpu_ack); end
    endtask

    task automatic test_video();
        exp_q.push_back('{1'b0, 16'h8005, 1'b0, 16'h0000, 16'hA55A});
        vid_addr = 14'h0005; vid_req = 1'b1;
        wait_grant(ok);
        e = exp_q.pop_front();
        n_vec++;
        if (!ok || {mem_addr, mem_we, mem_wdata} !== {e.addr, e.we, e.wdata}) begin
            n_err++;
            $display("FAIL video_req: got %h/%b/%h expected %h/%b/%h", mem_addr, mem_we, mem_wdata, e.addr, e.we, e.wdata);
        end
        mem_respond(3, 16'hA55A);
        n_vec++;
        if ({vid_ack, cpu_ack, vid_rdata, cpu_rdata} !== {2'b10, e.rdat, 8'hEF}) begin
            n_err++;
            $display("FAIL video_ack: got vack=%b ack=%b vrd=%h rd=%h expected 1 0 %h EF", vid_ack, cpu_ack, vid_rdata, cpu_rdata, e.rdat);
        end
        vid_req = 1'b0;
        tick();
        n_vec++;
        if (vid_ack !== 1'b0) begin n_err++; $display("FAIL video_pulse: got %b expected 0", vid_ack); end
    endtask

    task automatic test_contention();
        logic [15:0] last_rd;
        last_rd = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            if ((k % 3) == 2) exp_q.push_back('{1'b1, 16'h0042, 1'b0, 16'h0000, 16'h00C0 | 16'(k)});
            else              exp_q.push_back('{1'b0, 16'h8007, 1'b0, 16'h0000, 16'h00C0 | 16'(k)});
        end
        cpu_addr = 16'h0042; cpu_we = 1'b0; cpu_wdata = 8'h00; cpu_req = 1'b1;
        vid_addr = 14'h0007; vid_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_grant(ok);
            e = exp_q.pop_front();
            n_vec++;
            if (!ok || mem_addr !== e.addr || dut.starve_cnt_r > 4'd2) begin
                n_err++;
                $display("FAIL contention_grant%0d: got addr=%h starve=%0d expected addr=%h starve<=2", k, mem_addr, dut.starve_cnt_r, e.addr);
            end
            mem_respond(1, e.rdat);
            if (e.is_cpu) last_rd = e.rdat;
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
        tick();
        n_vec++;
        if (cpu_rdata !== last_rd[7:0]) begin
            n_err++;
            $display("FAIL contention_rdata: got %h expected %h", cpu_rdata, last_rd[7:0]);
        end
    endtask

    task automatic test_stray_ack();
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        tick();
        n_vec++;
        if ({cpu_ack, vid_ack, mem_req, cpu_rdata, vid_rdata} !== {3'b000, 8'hC5, 16'h00C4}) begin
            n_err++;
            $display("FAIL stray_ack: got ack=%b vack=%b req=%b rd=%h vrd=%h expected 0 0 0 C5 00C4", cpu_ack, vid_ack, mem_req, cpu_rdata, vid_rdata);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        cpu_addr = 16'h3333; cpu_we = 1'b0; cpu_req = 1'b1;
        wait_grant(ok);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_req = 1'b0;
        n_vec++;
        if (!ok || mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mid_req: got %b expected 0", mem_req); end
        seen = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            seen |= cpu_ack;
            tick();
        end
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL reset_mid_ack: got ack seen=1 expected 0"); end
        exp_q.push_back('{1'b0, 16'hBFFF, 1'b0, 16'h0000, 16'h1357});
        vid_addr = 14'h3FFF; vid_req = 1'b1;
        wait_grant(ok);
        e = exp_q.pop_front();
        n_vec++;
        if (!ok || mem_addr !== e.addr) begin n_err++; $display("FAIL reset_mid_vid_req: got %h expected %h", mem_addr, e.addr); end
        mem_respond(1, 16'h1357);
        vid_req = 1'b0;
        n_vec++;
        if ({vid_ack, vid_rdata} !== {1'b1, e.rdat}) begin
            n_err++;
            $display("FAIL reset_mid_vid_ack: got %b/%h expected 1/%h", vid_ack, vid_rdata, e.rdat);
        end
        tick();
    endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit dropped;
        cpu_addr = 16'h0100; cpu_we = 1'b0; cpu_req = 1'b1;
        wait_grant(ok);
        dropped = !ok;
        for (int i = 0; i < 7; i++) begin
            tick();
            dropped |= !mem_req;
        end
        n_vec++;
        if (dropped) begin n_err++; $display("FAIL timeout_hold: got early mem_req drop expected held 7 edges"); end
        tick();
        cpu_req = 1'b0;
        n_vec++;
        if ({mem_req, cpu_ack, cpu_rdata, err} !== {2'b01, 8'hFF, 1'b1}) begin
            n_err++;
            $display("FAIL timeout_abort: got req=%b ack=%b rd=%h err=%b expected 0 1 FF 1", mem_req, cpu_ack, cpu_rdata, err);
        end
        repeat (3) tick();
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b expected 1", err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b expected 0", err); end
    endtask
`else
    task automatic test_timeout();
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL err_tied: got %b expected 0", err); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        vid_req = 1'b0; vid_addr = 14'h0000; mem_ack = 1'b0; mem_rdata = 16'h0000;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_video();
        test_contention();
        test_stray_ack();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
